// File: rtl/uart_rx_word_packer.sv
// 8N1 UART receiver at 16x oversampling that packs four good bytes into a
// 32-bit word and presents it with an auto-incrementing address and write strobe.
module uart_rx_word_packer #(
    parameter int unsigned DIVISOR      = 79,
    parameter int unsigned DVSR_BIT     = 7,
    parameter int unsigned Data_Bits    = 8,
    parameter int unsigned ADDR         = 9,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            i_addr_clr,
    output logic [31:0]     data_out,
    output logic [ADDR-1:0] address,
    output logic            o_wr,
    output logic            o_frame_err,
    output logic            o_timeout
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    localparam int unsigned NW       = $clog2(Data_Bits + 1);
    localparam int unsigned TO_TICKS = TIMEOUT_BITS * 16;
    localparam int unsigned TW       = $clog2(TO_TICKS + 1);

    logic                 rx_meta, rx_s;
    logic [DVSR_BIT-1:0]  div_q;
    logic                 tick, start_det;
    state_t               state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [Data_Bits-1:0] sh_q, sh_d;
    logic                 byte_ok, frame_bad;
    logic [1:0]           k_q;
    logic [23:0]          lanes_q;
    logic [TW-1:0]        to_q;
    logic                 to_run, to_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick      = (div_q == DVSR_BIT'(DIVISOR - 1));
    assign start_det = (state_q == IDLE) && !rx_s;

    // Restarting on start detection aligns the sample points to the falling edge.
    always_ff @(posedge clk) begin
        if (!reset || start_det || tick) div_q <= '0;
        else                             div_q <= div_q + DVSR_BIT'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        sh_d      = sh_q;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                s_d     = '0;
            end
            START: if (tick) begin
                if (s_q == 4'd7) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            DATA: if (tick) begin
                if (s_q == 4'd15) begin
                    s_d  = '0;
                    sh_d = {rx_s, sh_q[Data_Bits-1:1]};
                    n_d  = n_q + NW'(1);
                    if (n_q == NW'(Data_Bits - 1)) state_d = STOP;
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            STOP: if (tick) begin
                if (s_q == 4'd15) begin
                    if (rx_s) begin
                        byte_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            WAIT_HIGH: if (tick && rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter is held at zero outside the idle-with-partial-word window, so a start bit clears it.
    assign to_run = (k_q != 2'd0) && (state_q == IDLE) && rx_s;
    assign to_hit = to_run && tick && (to_q == TW'(TO_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            k_q         <= '0;
            lanes_q     <= '0;
            data_out    <= '0;
            address     <= '0;
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
            o_timeout   <= 1'b0;
            to_q        <= '0;
        end else begin
            o_wr        <= 1'b0;
            o_frame_err <= frame_bad;
            o_timeout   <= 1'b0;
            if (!to_run || to_hit) to_q <= '0;
            else if (tick)         to_q <= to_q + TW'(1);
            if (o_wr) address <= address + ADDR'(1);
            // Clear wins over the post-strobe increment so the next word lands at 0.
            if (i_addr_clr) begin
                address <= '0;
                k_q     <= '0;
            end else if (frame_bad) begin
                k_q <= '0;
            end else if (to_hit) begin
                k_q       <= '0;
                o_timeout <= 1'b1;
            end else if (byte_ok) begin
                case (k_q)
                    2'd0: lanes_q[7:0]   <= sh_q[7:0];
                    2'd1: lanes_q[15:8]  <= sh_q[7:0];
                    2'd2: lanes_q[23:16] <= sh_q[7:0];
                    default: begin
                        data_out <= {sh_q[7:0], lanes_q};
                        o_wr     <= 1'b1;
                    end
                endcase
                k_q <= k_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed self-checking bench for uart_rx_word_packer (fast divider, 8-word address space).
module tb_uart_rx_word_packer;

    localparam int DIV      = 4;
    localparam int AW       = 3;
    localparam int BIT_CLKS = 16 * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          i_addr_clr = 1'b0;
    logic [31:0]   data_out;
    logic [AW-1:0] address;
    logic          o_wr, o_frame_err, o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_word_packer #(
        .DIVISOR(DIV), .DVSR_BIT(3), .Data_Bits(8), .ADDR(AW), .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .i_addr_clr(i_addr_clr),
        .data_out(data_out), .address(address), .o_wr(o_wr),
        .o_frame_err(o_frame_err), .o_timeout(o_timeout)
    );

    // Observed write strobes, address on the cycle after each strobe, pulse counts.
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [AW-1:0] post_addr_q[$];
    int ferr_cnt = 0, tout_cnt = 0, wr_long = 0;
    logic wr_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_prev) post_addr_q.push_back(address);
        if (o_wr) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(data_out);
            if (wr_prev) wr_long++;
        end
        if (o_frame_err) ferr_cnt++;
        if (o_timeout) tout_cnt++;
        wr_prev = o_wr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        post_addr_q.delete();
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
        checks++; if (address !== 3'd0) begin errors++; $display("FAIL reset_address: got %0d expected 0", address); end
        checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL reset_o_wr: got %b expected 0", o_wr); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_o_frame_err: got %b expected 0", o_frame_err); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_o_timeout: got %b expected 0", o_timeout); end
        reset = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_first_word();
        clear_mon();
        send_word(32'h12345678);
        idle_bits(1);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL first_wr_count: got %0d expected 1", wr_addr_q.size()); end
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd0) begin errors++; $display("FAIL first_addr: expected 0"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'h12345678) begin errors++; $display("FAIL first_data: got %h expected 12345678", data_out); end
        checks++; if ((post_addr_q.size() > 0 ? post_addr_q[0] : 3'bx) !== 3'd1) begin errors++; $display("FAIL first_post_addr: got %0d expected 1", address); end
        checks++; if (wr_long != 0) begin errors++; $display("FAIL wr_one_cycle: got %0d extended strobes expected 0", wr_long); end
    endtask

    task automatic test_glitch();
        int f0, t0;
        clear_mon();
        f0 = ferr_cnt; t0 = tout_cnt;
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL glitch_wr: got %0d strobes expected 0", wr_addr_q.size()); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
        checks++; if (tout_cnt != t0) begin errors++; $display("FAIL glitch_tout: got %0d expected %0d", tout_cnt, t0); end
        send_word(32'hA1B2C3D4);
        idle_bits(1);
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd1) begin errors++; $display("FAIL glitch_next_addr: expected 1"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'hA1B2C3D4) begin errors++; $display("FAIL glitch_next_data: got %h expected a1b2c3d4", data_out); end
    endtask

    task automatic test_frame_error();
        int f0;
        clear_mon();
        f0 = ferr_cnt;
        send_byte(8'hEE, 1'b1);
        send_byte(8'h55, 1'b0);
        idle_bits(2);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL ferr_no_wr: got %0d strobes expected 0", wr_addr_q.size()); end
        send_word(32'h04030201);
        idle_bits(1);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL ferr_wr_count: got %0d expected 1", wr_addr_q.size()); end
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd2) begin errors++; $display("FAIL ferr_addr: expected 2"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'h04030201) begin errors++; $display("FAIL ferr_data: got %h expected 04030201", data_out); end
    endtask

    task automatic test_timeout();
        int t0;
        clear_mon();
        t0 = tout_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_bits(33);
        checks++; if (tout_cnt - t0 != 1) begin errors++; $display("FAIL tout_count: got %0d expected 1", tout_cnt - t0); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL tout_no_wr: got %0d strobes expected 0", wr_addr_q.size()); end
        checks++; if (address !== 3'd3) begin errors++; $display("FAIL tout_addr_hold: got %0d expected 3", address); end
        send_word(32'hDDCCBBAA);
        idle_bits(1);
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd3) begin errors++; $display("FAIL tout_next_addr: expected 3"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'hDDCCBBAA) begin errors++; $display("FAIL tout_next_data: got %h expected ddccbbaa", data_out); end
        checks++; if (tout_cnt - t0 != 1) begin errors++; $display("FAIL tout_single: got %0d expected 1", tout_cnt - t0); end
    endtask

    task automatic test_addr_clr();
        int n;
        clear_mon();
        send_byte(8'h10, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h12, 1'b1);
        fork
            send_byte(8'h13, 1'b1);
            begin
                n = 0;
                while (o_wr !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (n >= 2000) begin errors++; $display("FAIL clr_wait_wr: got no strobe expected strobe within 2000 cycles"); end
                i_addr_clr = 1'b1;
                @(negedge clk);
                i_addr_clr = 1'b0;
            end
        join
        idle_bits(1);
        send_word(32'h33323130);
        send_byte(8'h99, 1'b1);
        i_addr_clr = 1'b1;
        @(negedge clk);
        i_addr_clr = 1'b0;
        send_word(32'h23222120);
        idle_bits(1);
        checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL clr_wr_count: got %0d expected 3", wr_addr_q.size()); end
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd4) begin errors++; $display("FAIL clr_strobe_old_addr: expected 4"); end
        checks++; if ((post_addr_q.size() > 0 ? post_addr_q[0] : 3'bx) !== 3'd0) begin errors++; $display("FAIL clr_post_addr: expected 0"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'h13121110) begin errors++; $display("FAIL clr_data0: expected 13121110"); end
        checks++; if ((wr_addr_q.size() > 1 ? wr_addr_q[1] : 3'bx) !== 3'd0) begin errors++; $display("FAIL clr_next_addr: expected 0"); end
        checks++; if ((wr_addr_q.size() > 2 ? wr_addr_q[2] : 3'bx) !== 3'd0) begin errors++; $display("FAIL clr_partial_addr: expected 0"); end
        checks++; if ((wr_data_q.size() > 2 ? wr_data_q[2] : 32'bx) !== 32'h23222120) begin errors++; $display("FAIL clr_partial_data: got %h expected 23222120", data_out); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        clear_mon();
        i_addr_clr = 1'b1;
        @(negedge clk);
        i_addr_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w = 32'h03020100 + i * 32'h04040404;
            send_word(w);
        end
        idle_bits(1);
        checks++; if (wr_addr_q.size() != 9) begin errors++; $display("FAIL wrap_wr_count: got %0d expected 9", wr_addr_q.size()); end
        for (int i = 0; i < 9; i++) begin
            w = 32'h03020100 + i * 32'h04040404;
            checks++; if ((wr_addr_q.size() > i ? wr_addr_q[i] : 3'bx) !== AW'(i % 8)) begin errors++; $display("FAIL wrap_addr[%0d]: expected %0d", i, i % 8); end
            checks++; if ((wr_data_q.size() > i ? wr_data_q[i] : 32'bx) !== w) begin errors++; $display("FAIL wrap_data[%0d]: expected %h", i, w); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pb;
        int f0;
        clear_mon();
        f0 = ferr_cnt;
        pb = 8'h3C;
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = pb[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (address !== 3'd0) begin errors++; $display("FAIL rst_mid_address: got %0d expected 0", address); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", data_out); end
        rx = 1'b1;
        reset = 1'b1;
        idle_bits(2);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL rst_mid_no_wr: got %0d strobes expected 0", wr_addr_q.size()); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL rst_mid_ferr: got %0d expected %0d", ferr_cnt, f0); end
        send_word(32'h87654321);
        idle_bits(1);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL rst_mid_wr_count: got %0d expected 1", wr_addr_q.size()); end
        checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 3'bx) !== 3'd0) begin errors++; $display("FAIL rst_mid_addr: expected 0"); end
        checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'bx) !== 32'h87654321) begin errors++; $display("FAIL rst_mid_word: got %h expected 87654321", data_out); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_glitch();
        test_frame_error();
        test_timeout();
        test_addr_clr();
        test_wrap();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
Receive-side counterpart of the UART transmit path. Samples the serial `rx` line as 8N1 at 16x oversampling and deserialises bytes. Packs every four consecutive good bytes into a 32-bit word. Presents each word with an auto-incrementing 9-bit address and a one-cycle write strobe, for a 512x32 capture RAM or a host-command decoder.

Parameters:
DIVISOR, 79, clk cycles per oversample tick (tick period = DIVISOR clocks; 16 ticks per bit)
DVSR_BIT, 7, width of the tick divider counter
Data_Bits, 8, data bits per UART frame
ADDR, 9, output address width (512-word space)
TIMEOUT_BITS, 32, idle bit-times after which a partial word is discarded

Ports:
clk  input  1  system clock (12 MHz)
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
i_addr_clr  input  1  one-cycle pulse; returns address to 0 and discards any partial word
data_out  output  32  assembled word; first received byte in [7:0], fourth in [31:24]
address  output  ADDR  address for data_out while o_wr is high
o_wr  output  1  one-cycle write strobe
o_frame_err  output  1  one-cycle pulse on a bad stop bit
o_timeout  output  1  one-cycle pulse when a partial word is discarded on timeout

Behaviour:
- Reset (reset==0 at posedge clk): data_out=0, address=0, o_wr=0, o_frame_err=0, o_timeout=0. Byte count, FSM, divider and timeout counter are cleared; the synchroniser is preset to 1. Reset mid-frame abandons the frame with no strobe.
- rx passes through a 2-FF synchroniser preset to 1. All references to rx below mean the synchronised value.
- Tick: the divider counts 0..DIVISOR-1 and pulses tick on DIVISOR-1. It is free-running except that it restarts at 0 on the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx==0 -> START, tick count s=0.
  - START: at s==7 (mid start bit), rx==0 -> DATA with s=0 and n=0. rx==1 -> IDLE (glitch; no error).
  - DATA: at s==15, shift rx into the byte LSB-first and increment n. After Data_Bits samples -> STOP.
  - STOP: at s==15, rx==1 -> byte good, go to IDLE. rx==0 -> pulse o_frame_err, discard the byte and any partial word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx==1 for one tick, then go to IDLE. This prevents a break from retriggering.
- Packing: each good byte is written into lane k (k=0..3, bits [8k+7:8k]) of a shadow register, then k increments.
  - On the 4th byte, data_out takes the full word and o_wr goes high on the clock after the stop-bit sample (latency 1 clk).
  - o_wr lasts exactly 1 cycle, during which address holds the write address.
  - address increments on the cycle after o_wr and wraps from 511 to 0 with no flag.
  - data_out holds its value until the next word.
- Timeout: the counter runs only while 0<k<4 and the FSM is IDLE. Sixteen ticks count as one bit-time. When the count reaches TIMEOUT_BITS bit-times, k returns to 0, o_timeout pulses once and address is unchanged. Any start bit clears the counter.
- i_addr_clr sets address to 0 and k to 0. If it coincides with o_wr, the strobe still completes at the old address and the next word goes to address 0. It does not abort an in-flight frame.
- Back-to-back frames (stop bit directly followed by a start bit) must be received with no loss.

Test Plan:
- DIVISOR=4; send 0x78,0x56,0x34,0x12 back-to-back -> one o_wr pulse, data_out=0x12345678, address=0; address=1 on the next cycle.
- Send 512 words of incrementing pattern -> o_wr at addresses 0..511; the 513th word is written at address 0.
- Send 0x55 with stop bit forced low, then line high, then 4 good bytes 0x01..0x04 -> one o_frame_err pulse, no o_wr for the bad frame, then data_out=0x04030201 at address 0.
- Pulse rx low for 3 ticks (under half a bit) -> no state change beyond START->IDLE, no strobes.
- Send 2 bytes, idle for 33 bit-times -> one o_timeout pulse; then 4 bytes 0xAA,0xBB,0xCC,0xDD -> data_out=0xDDCCBBAA at the unchanged address.
- Assert reset low during bit 4 of the third byte, release, send 4 bytes -> no o_wr before reset; the first word after reset is written at address 0.
